// File: rtl/stream_mux_pkg.sv
// Shared helpers for stream_mux_rr: round-robin pointer advance and one-hot decode.
package stream_mux_pkg;

    // Upper bound on channel count accepted by the one-hot decoder.
    localparam int MAX_CH = 64;

    function automatic int ptr_advance(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        req_rot = N'({req, req} >> ptr);
        gnt_rot = req_rot & (~req_rot + 1'b1);
        grant   = N'(({gnt_rot, gnt_rot} << ptr) >> N);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with round-robin arbitration and a registered output stage.
// Optional packet locking (winner keeps the grant until in_last) via STREAM_MUX_RR_PACKET_LOCK_EN.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 4,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic [DATA_W-1:0] in_data [N_CH],
    input  logic [N_CH-1:0]   in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_last
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
    logic              out_last_q,  out_last_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    logic [N_CH-1:0]   arb_grant;
    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  win_idx;
    logic              any_grant;
    logic              load;
    logic              adv_ptr;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
    // The locked channel is always the last winner, which out_sel_q already holds.
    logic locked_q, locked_d;

    always_comb begin
        grant = arb_grant;
        if (locked_q) begin
            grant            = '0;
            grant[out_sel_q] = in_valid[out_sel_q];
        end
    end

    assign adv_ptr = in_last[win_idx];

    always_comb begin
        locked_d = locked_q;
        if (load && any_grant) locked_d = !in_last[win_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) locked_q <= 1'b0;
        else     locked_q <= locked_d;
    end
`else
    assign grant   = arb_grant;
    assign adv_ptr = 1'b1;
`endif

    assign load      = !out_valid_q || out_ready;
    assign any_grant = |grant;
    assign win_idx   = SEL_W'(onehot_to_idx(MAX_CH'(grant)));
    assign in_ready  = {N_CH{load && !rst}} & grant;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any_grant;
            if (any_grant) begin
                out_data_d = in_data[win_idx];
                out_sel_d  = win_idx;
                out_last_d = in_last[win_idx];
                if (adv_ptr) ptr_d = SEL_W'(ptr_advance(int'(win_idx), N_CH));
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: queue-based producers, per-cycle reference model,
// directed pinning sequences and a randomized phase.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int DW = 4;
`ifdef STREAM_MUX_RR_PACKET_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [DW-1:0] in_data [N];
    logic [N-1:0]  in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_last;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    // Each producer holds its pending beats; valid means "queue not empty".
    beat_t q [N][$];

    int            m_ptr, m_lock_ch, m_sel;
    bit            m_locked, m_valid, m_last;
    logic [DW-1:0] m_data;

    int            total = 0;
    int            bad   = 0;
    int            sel_log[$];
    int            data_log[$];
    logic [N-1:0]  s_ready;
    bit            s_valid;
    int            s_sel, s_data;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int winner();
        if (LOCK_EN && m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic push(input int c, input int d, input bit l);
        beat_t b;
        b.d = DW'(d);
        b.l = l;
        q[c].push_back(b);
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            in_valid[c] = q[c].size() > 0;
            in_data[c]  = (q[c].size() > 0) ? q[c][0].d : '0;
            in_last[c]  = (q[c].size() > 0) ? q[c][0].l : 1'b0;
        end
    endtask

    task automatic compare();
        int           w;
        logic [N-1:0] exp_rdy;
        w       = winner();
        exp_rdy = '0;
        if (!rst && (!m_valid || out_ready) && w >= 0) exp_rdy[w] = 1'b1;
        check("in_ready",  {28'd0, in_ready}, {28'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_data",  {28'd0, out_data}, {28'd0, m_data});
        check("out_sel",   {30'd0, out_sel}, m_sel);
        check("out_last",  {31'd0, out_last}, {31'd0, m_last});
        s_ready = in_ready;
        s_valid = out_valid;
        s_sel   = int'(out_sel);
        s_data  = int'(out_data);
        sel_log.push_back(out_valid ? int'(out_sel) : -1);
        data_log.push_back(out_valid ? int'(out_data) : -1);
    endtask

    task automatic model_update();
        int w;
        if (rst) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_last = 0;
            m_ptr = 0; m_locked = 0; m_lock_ch = 0;
        end else if (!m_valid || out_ready) begin
            w = winner();
            if (w < 0) begin
                m_valid = 0;
            end else begin
                m_valid = 1;
                m_data  = q[w][0].d;
                m_last  = q[w][0].l;
                m_sel   = w;
                void'(q[w].pop_front());
                if (!LOCK_EN || m_last) begin
                    m_ptr    = (w + 1) % N;
                    m_locked = 0;
                end else begin
                    m_locked  = 1;
                    m_lock_ch = w;
                end
            end
        end
    endtask

    task automatic tick();
        drive();
        #1;
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int exp_fair_sel[9] = '{-1, 0, 1, 2, 3, 0, 1, 2, 3};
    int exp_fair_dat[9] = '{-1, 0, 3, 6, 9, 0, 3, 6, 9};
    int exp_alt[5]      = '{-1, 1, 3, 1, 3};
    int exp_pkt[5];

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        m_valid = 0; m_data = '0; m_sel = 0; m_last = 0;
        m_ptr = 0; m_locked = 0; m_lock_ch = 0;
        drive();
        @(posedge clk);
        model_update();
        @(negedge clk);

        // Reset with every channel valid, then fair rotation over all four channels.
        for (int c = 0; c < N; c++) begin
            for (int b = 0; b < ((c == 0) ? 3 : 2); b++) push(c, c * 3, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", {28'd0, s_ready}, 0);
            check("rst_out_valid", {31'd0, s_valid}, 0);
        end
        rst = 1'b0;
        sel_log.delete();
        data_log.delete();
        run(9);
        for (int i = 0; i < 9; i++) begin
            check("fair_sel", sel_log[i], exp_fair_sel[i]);
            check("fair_data", data_log[i], exp_fair_dat[i]);
        end
        run(2);

        // Only channels 1 and 3: alternate with no bubbles.
        for (int b = 0; b < 3; b++) push(1, 3, 1'b1);
        for (int b = 0; b < 2; b++) push(3, 9, 1'b1);
        sel_log.delete();
        run(5);
        for (int i = 0; i < 5; i++) check("alt_sel", sel_log[i], exp_alt[i]);
        run(2);

        // Stall with a beat held, then resume on the next channel in order.
        for (int c = 0; c < N; c++) push(c, c * 3, 1'b1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_in_ready", {28'd0, s_ready}, 0);
            check("stall_sel", s_sel, 2);
            check("stall_data", s_data, 6);
            check("stall_valid", {31'd0, s_valid}, 1);
        end
        out_ready = 1'b1;
        tick();
        check("resume_in_ready", {28'd0, s_ready}, 8);
        tick();
        check("resume_sel", s_sel, 3);
        run(3);

        // Channel 2 sends a 3-beat packet while channel 0 stays valid.
        for (int b = 0; b < 3; b++) push(0, 1, 1'b1);
        push(2, 10, 1'b0);
        push(2, 11, 1'b0);
        push(2, 12, 1'b1);
        if (LOCK_EN) exp_pkt = '{-1, 2, 2, 2, 0};
        else         exp_pkt = '{-1, 2, 0, 2, 0};
        sel_log.delete();
        run(5);
        for (int i = 0; i < 5; i++) check("pkt_sel", sel_log[i], exp_pkt[i]);
        run(6);

        // Reset while a beat is held mid-packet: arbitration restarts from channel 0.
        push(3, 7, 1'b0);
        push(3, 8, 1'b1);
        tick();
        out_ready = 1'b0;
        push(1, 4, 1'b1);
        tick();
        check("prerst_valid", {31'd0, s_valid}, 1);
        check("prerst_sel", s_sel, 3);
        rst = 1'b1;
        run(2);
        rst       = 1'b0;
        out_ready = 1'b1;
        sel_log.delete();
        run(3);
        check("postrst_valid", sel_log[0], -1);
        check("postrst_sel", sel_log[1], 1);
        run(4);

        // Randomized traffic, backpressure and occasional reset against the model.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                if (q[c].size() < 3 && $urandom_range(0, 3) == 0)
                    push(c, int'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
            end
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
